// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the conduit bridge state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

endpackage

// File: rtl/ahb_wstrb_gen.sv
// Byte-lane strobe, misalignment and oversize flags for one AHB address phase.
module ahb_wstrb_gen #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned LANES      = DATA_WIDTH / 8,
  localparam int unsigned LANE_BITS  = $clog2(LANES)
) (
  input  logic [2:0]           hsize,
  input  logic [LANE_BITS-1:0] addr_lo,
  output logic [LANES-1:0]     wstrb_c,
  output logic                 misalign_c,
  output logic                 size_err_c
);

  int unsigned lo;
  int unsigned nbytes;

  assign lo     = 32'(addr_lo);
  assign nbytes = 32'd1 << hsize;

  // Strobe covers 2^hsize lanes starting at the low address bits.
  always_comb begin
    size_err_c = 32'(hsize) > LANE_BITS;
    misalign_c = 1'b0;
    wstrb_c    = '0;
    if (!size_err_c) begin
      misalign_c = (lo & (nbytes - 32'd1)) != 32'd0;
      for (int unsigned i = 0; i < LANES; i++) begin
        wstrb_c[i] = (i >= lo) && (i < lo + nbytes);
      end
    end
  end

endmodule

// File: rtl/ahb_conduit_bridge.sv
// AHB-Lite slave turning pipelined transfers into req/ack transactions on a
// multi-channel conduit, with address-phase checks and a wait-state timeout.
module ahb_conduit_bridge
  import ahb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 12,
  parameter  int unsigned NUM_CH     = 2,
  parameter  int unsigned TIMEOUT    = 16,
  localparam int unsigned STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  con_req,
  output logic                  con_we,
  output logic [NUM_CH-1:0]     con_sel,
  output logic [ADDR_WIDTH-1:0] con_addr,
  output logic [STRB_W-1:0]     con_wstrb,
  output logic [DATA_WIDTH-1:0] con_wdata,
  input  logic [DATA_WIDTH-1:0] con_rdata,
  input  logic                  con_ack,
  input  logic                  con_slverr
);

  localparam int unsigned LANE_BITS = $clog2(STRB_W);
  localparam int unsigned CH_BITS   = $clog2(NUM_CH);
  localparam int unsigned CH_W      = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);

  bridge_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch;
  logic [NUM_CH-1:0] sel_c;
  logic [STRB_W-1:0] wstrb_c;
  logic misalign_c, size_err_c, ch_err_c, addr_err_c;
  logic ready_st_c, accept_c;
  logic load_addr_c, load_rdata_c;
  logic hreadyout_d, hresp_d, con_req_d;

  // hburst is irrelevant since every beat carries its own address.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, htrans[0]};

  assign con_wdata = hwdata;

  ahb_wstrb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wstrb (
    .hsize      (hsize),
    .addr_lo    (haddr[LANE_BITS-1:0]),
    .wstrb_c    (wstrb_c),
    .misalign_c (misalign_c),
    .size_err_c (size_err_c)
  );

  // Channel index comes from the top address bits.
  generate
    if (CH_BITS == 0) begin : g_one_ch
      assign ch = '0;
    end else begin : g_multi_ch
      assign ch = haddr[ADDR_WIDTH-1 -: CH_BITS];
    end
  endgenerate

  assign ch_err_c   = 32'(ch) >= NUM_CH;
  assign addr_err_c = ch_err_c || size_err_c || misalign_c;

  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_c[i] = (32'(ch) == i);
    end
  end

  assign ready_st_c = (state_q == ST_IDLE) || (state_q == ST_RESP) || (state_q == ST_ERR2);
  assign accept_c   = ready_st_c && hsel && hready && htrans[1];

  // Next state, timeout counter and next registered response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_addr_c  = 1'b0;
    load_rdata_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (!accept_c) begin
          state_d = ST_IDLE;
        end else if (addr_err_c) begin
          state_d = ST_ERR1;
        end else begin
          state_d     = ST_XFER;
          cnt_d       = '0;
          load_addr_c = 1'b1;
        end
      end
      ST_XFER: begin
        if (con_ack) begin
          state_d      = con_slverr ? ST_ERR1 : ST_RESP;
          load_rdata_c = !con_slverr && !con_we;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR1;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_RESP) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    con_req_d   = (state_d == ST_XFER);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      con_req   <= 1'b0;
      con_we    <= 1'b0;
      con_sel   <= '0;
      con_addr  <= '0;
      con_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hreadyout <= hreadyout_d;
      hresp     <= hresp_d;
      con_req   <= con_req_d;
      if (load_addr_c) begin
        con_we    <= hwrite;
        con_sel   <= sel_c;
        con_addr  <= haddr;
        con_wstrb <= wstrb_c;
      end
      if (load_rdata_c) begin
        hrdata <= con_rdata;
      end
    end
  end

endmodule
